// File: rtl/data_mem_sw.sv
// rtl/data_mem_sw.sv - store-side byte-lane aligner and data-memory write handshake
// Optional macro MISALIGNED_SPLIT_EN: word-crossing stores are written as two beats.
module data_mem_sw #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Store_Valid,
   output logic                  Store_Ready,
   input  logic [2:0]            Lw_Sw_OP,
   input  logic [ADDR_WIDTH-1:0] Store_Addr,
   input  logic [31:0]           Store_Data,
   output logic                  Mem_Req,
   input  logic                  Mem_Ack,
   output logic [ADDR_WIDTH-1:0] Mem_Addr,
   output logic [31:0]           Mem_Wdata,
   output logic [3:0]            Mem_Byte_En,
   output logic                  Store_Done,
   output logic                  Store_Err
);

   localparam logic [2:0] OP_SB = 3'b000;
   localparam logic [2:0] OP_SH = 3'b001;
   localparam logic [2:0] OP_SW = 3'b010;
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t        state, state_nxt;
   logic [1:0]    offs;
   logic [31:0]   data_mask;
   logic [3:0]    en_base;
   logic          illegal;
   logic          reject;
   logic [31:0]   lane_data;
   logic [3:0]    lane_en;
   logic          second_beat;
   logic [CW-1:0] tmo_cnt;
   logic          timeout;
   logic          accept;

   always_comb begin
      offs      = Store_Addr[1:0];
      illegal   = 1'b0;
      data_mask = 32'hFFFF_FFFF;
      en_base   = 4'b1111;
      case (Lw_Sw_OP)
         OP_SB: begin
            data_mask = 32'h0000_00FF;
            en_base   = 4'b0001;
         end
         OP_SH: begin
            data_mask = 32'h0000_FFFF;
            en_base   = 4'b0011;
         end
         OP_SW: ;
         default: illegal = 1'b1;
      endcase
   end

`ifdef MISALIGNED_SPLIT_EN
   // 64-bit view: low word is beat 0, high word is the spill into the next word.
   logic [63:0] wide_data;
   logic [7:0]  wide_en;
   logic        split_q;
   logic [31:0] b1_wdata;
   logic [3:0]  b1_en;

   assign wide_data   = {32'b0, Store_Data & data_mask} << {offs, 3'b000};
   assign wide_en     = {4'b0, en_base} << offs;
   assign lane_data   = wide_data[31:0];
   assign lane_en     = wide_en[3:0];
   assign reject      = illegal;
   assign second_beat = split_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         split_q  <= 1'b0;
         b1_wdata <= 32'b0;
         b1_en    <= 4'b0;
      end else if (accept && !reject) begin
         split_q  <= |wide_en[7:4];
         b1_wdata <= wide_data[63:32];
         b1_en    <= wide_en[7:4];
      end else if (state == BEAT0 && Mem_Ack) begin
         split_q  <= 1'b0;
      end
   end
`else
   logic misaligned;

   assign misaligned  = (Lw_Sw_OP == OP_SH && offs[0]) || (Lw_Sw_OP == OP_SW && offs != 2'b00);
   assign lane_data   = (Store_Data & data_mask) << {offs, 3'b000};
   assign lane_en     = en_base << offs;
   assign reject      = illegal | misaligned;
   assign second_beat = 1'b0;
`endif

   assign accept  = Store_Valid && Store_Ready;
   // Ack is checked before timeout wherever both are used, so ack wins a tie.
   assign timeout = (TIMEOUT_CYCLES != 0) && !Mem_Ack && (tmo_cnt == TMO_LAST);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !reject) state_nxt = BEAT0;
         BEAT0: begin
            if (Mem_Ack)      state_nxt = second_beat ? BEAT1 : IDLE;
            else if (timeout) state_nxt = IDLE;
         end
         BEAT1:   if (Mem_Ack || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Store_Ready = (state == IDLE);
      Mem_Req     = (state != IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Mem_Addr    <= '0;
         Mem_Wdata   <= 32'b0;
         Mem_Byte_En <= 4'b0;
         Store_Done  <= 1'b0;
         Store_Err   <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         Store_Done <= 1'b0;
         Store_Err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (reject) begin
                     Store_Err <= 1'b1;
                  end else begin
                     Mem_Addr    <= {Store_Addr[ADDR_WIDTH-1:2], 2'b00};
                     Mem_Wdata   <= lane_data;
                     Mem_Byte_En <= lane_en;
                     tmo_cnt     <= '0;
                  end
               end
            end
            BEAT0: begin
               if (Mem_Ack) begin
                  if (second_beat) begin
`ifdef MISALIGNED_SPLIT_EN
                     Mem_Addr    <= Mem_Addr + ADDR_WIDTH'(4);
                     Mem_Wdata   <= b1_wdata;
                     Mem_Byte_En <= b1_en;
`endif
                     tmo_cnt     <= '0;
                  end else begin
                     Store_Done <= 1'b1;
                  end
               end else if (timeout) begin
                  Store_Err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            BEAT1: begin
               if (Mem_Ack)      Store_Done <= 1'b1;
               else if (timeout) Store_Err  <= 1'b1;
               else              tmo_cnt    <= tmo_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_sw.sv
// tb/tb_data_mem_sw.sv - directed table-driven bench for data_mem_sw (TIMEOUT_CYCLES=4)
module tb_data_mem_sw;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Store_Valid;
   logic        Store_Ready;
   logic [2:0]  Lw_Sw_OP;
   logic [31:0] Store_Addr;
   logic [31:0] Store_Data;
   logic        Mem_Req;
   logic        Mem_Ack;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_Wdata;
   logic [3:0]  Mem_Byte_En;
   logic        Store_Done;
   logic        Store_Err;

   int errors = 0;
   int checks = 0;

   data_mem_sw #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Store_Valid(Store_Valid), .Store_Ready(Store_Ready),
      .Lw_Sw_OP(Lw_Sw_OP), .Store_Addr(Store_Addr), .Store_Data(Store_Data),
      .Mem_Req(Mem_Req), .Mem_Ack(Mem_Ack), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
      .Mem_Byte_En(Mem_Byte_En), .Store_Done(Store_Done), .Store_Err(Store_Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      logic [31:0] maddr;
      logic [3:0]  en;
      logic [31:0] wdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
      Store_Valid = 1'b1;
      Lw_Sw_OP    = op;
      Store_Addr  = addr;
      Store_Data  = data;
      tick();
      Store_Valid = 1'b0;
   endtask

   task automatic check_beat(input string name, input logic [31:0] a, input logic [3:0] en,
                             input logic [31:0] wd);
      check({name, " req"}, 32'(Mem_Req), 32'd1);
      check({name, " addr"}, Mem_Addr, a);
      check({name, " en"}, 32'(Mem_Byte_En), 32'(en));
      check({name, " wdata"}, Mem_Wdata, wd);
   endtask

   always @(negedge Clk) begin
      if (Reset_n && Store_Done && Store_Err) begin
         errors++;
         $display("FAIL done_and_err: got both high expected exclusive");
      end
   end

   initial begin
      vec_t vecs[8];
      int   cnt;

      vecs[0] = '{3'b000, 32'h202, 32'h0000_00A5, 1'b0, 32'h200, 4'b0100, 32'h00A5_0000};
      vecs[1] = '{3'b001, 32'h106, 32'h0000_BEEF, 1'b0, 32'h104, 4'b1100, 32'hBEEF_0000};
      vecs[2] = '{3'b010, 32'h100, 32'h1122_3344, 1'b0, 32'h100, 4'b1111, 32'h1122_3344};
      vecs[3] = '{3'b000, 32'h003, 32'hFFFF_FF5A, 1'b0, 32'h000, 4'b1000, 32'h5A00_0000};
      vecs[4] = '{3'b001, 32'h010, 32'h1234_5678, 1'b0, 32'h010, 4'b0011, 32'h0000_5678};
      vecs[5] = '{3'b000, 32'h001, 32'h0000_0077, 1'b0, 32'h000, 4'b0010, 32'h0000_7700};
      vecs[6] = '{3'b011, 32'h100, 32'h1234_5678, 1'b1, 32'h0,   4'b0,    32'h0};
      vecs[7] = '{3'b111, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'h0,   4'b0,    32'h0};

      Reset_n = 1'b0; Store_Valid = 1'b0; Mem_Ack = 1'b0;
      Lw_Sw_OP = 3'b000; Store_Addr = 32'h0; Store_Data = 32'h0;
      #12;
      check("rst ready", 32'(Store_Ready), 32'd1);
      check("rst req", 32'(Mem_Req), 32'd0);
      check("rst addr", Mem_Addr, 32'h0);
      check("rst wdata", Mem_Wdata, 32'h0);
      check("rst en", 32'(Mem_Byte_En), 32'd0);
      check("rst done", 32'(Store_Done), 32'd0);
      check("rst err", 32'(Store_Err), 32'd0);
      Reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].op, vecs[i].addr, vecs[i].data);
         if (vecs[i].err) begin
            check($sformatf("v%0d err", i), 32'(Store_Err), 32'd1);
            check($sformatf("v%0d noreq", i), 32'(Mem_Req), 32'd0);
            check($sformatf("v%0d ready", i), 32'(Store_Ready), 32'd1);
         end else begin
            check_beat($sformatf("v%0d", i), vecs[i].maddr, vecs[i].en, vecs[i].wdata);
            Mem_Ack = 1'b1;
            tick();
            Mem_Ack = 1'b0;
            check($sformatf("v%0d done", i), 32'(Store_Done), 32'd1);
            check($sformatf("v%0d req_low", i), 32'(Mem_Req), 32'd0);
         end
         tick();
      end

      // Three wait cycles, ack on the fourth: also the ack/timeout tie.
      issue(3'b000, 32'h202, 32'h0000_00A5);
      for (int w = 0; w < 4; w++) begin
         check_beat($sformatf("wait%0d", w), 32'h200, 4'b0100, 32'h00A5_0000);
         check($sformatf("wait%0d nodone", w), 32'(Store_Done), 32'd0);
         if (w == 3) Mem_Ack = 1'b1;
         tick();
      end
      Mem_Ack = 1'b0;
      check("wait done", 32'(Store_Done), 32'd1);
      check("wait noerr", 32'(Store_Err), 32'd0);
      check("wait ready", 32'(Store_Ready), 32'd1);
      tick();

      // Timeout with no ack.
      issue(3'b010, 32'h100, 32'h1122_3344);
      cnt = 0;
      while (Mem_Req && cnt < 20) begin
         cnt++;
         tick();
      end
      check("tmo req_cycles", 32'(cnt), 32'd4);
      check("tmo err", 32'(Store_Err), 32'd1);
      check("tmo nodone", 32'(Store_Done), 32'd0);
      check("tmo ready", 32'(Store_Ready), 32'd1);
      tick();

      // Ack while idle is ignored.
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("idle ack done", 32'(Store_Done), 32'd0);
      check("idle ack req", 32'(Mem_Req), 32'd0);

      // Asynchronous reset mid-BEAT0.
      issue(3'b010, 32'h400, 32'hCAFE_F00D);
      check("prerst req", 32'(Mem_Req), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("arst req", 32'(Mem_Req), 32'd0);
      check("arst addr", Mem_Addr, 32'h0);
      check("arst en", 32'(Mem_Byte_En), 32'd0);
      check("arst wdata", Mem_Wdata, 32'h0);
      check("arst ready", 32'(Store_Ready), 32'd1);
      tick();
      Reset_n = 1'b1;
      tick();
      check("arst nodone", 32'(Store_Done), 32'd0);
      check("arst noerr", 32'(Store_Err), 32'd0);

      // Back-to-back SBs with Store_Valid held.
      Store_Valid = 1'b1; Lw_Sw_OP = 3'b000; Store_Addr = 32'h300; Store_Data = 32'h11;
      tick();
      check_beat("b2b first", 32'h300, 4'b0001, 32'h0000_0011);
      Store_Addr = 32'h305; Store_Data = 32'h22; Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("b2b done1", 32'(Store_Done), 32'd1);
      check("b2b ready", 32'(Store_Ready), 32'd1);
      tick();
      Store_Valid = 1'b0;
      check_beat("b2b second", 32'h304, 4'b0010, 32'h0000_2200);
      check("b2b nodone", 32'(Store_Done), 32'd0);
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("b2b done2", 32'(Store_Done), 32'd1);
      tick();
      check("b2b nodup req", 32'(Mem_Req), 32'd0);
      check("b2b nodup done", 32'(Store_Done), 32'd0);

`ifdef MISALIGNED_SPLIT_EN
      issue(3'b010, 32'h103, 32'h1122_3344);
      check_beat("split b0", 32'h100, 4'b1000, 32'h4400_0000);
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("split b0 nodone", 32'(Store_Done), 32'd0);
      check_beat("split b1", 32'h104, 4'b0111, 32'h0011_2233);
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("split done", 32'(Store_Done), 32'd1);
      tick();
      issue(3'b001, 32'h101, 32'h0000_BEEF);
      check_beat("sh odd", 32'h100, 4'b0110, 32'h00BE_EF00);
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      check("sh odd done", 32'(Store_Done), 32'd1);
      tick();
`else
      issue(3'b010, 32'h101, 32'h1122_3344);
      check("mis sw err", 32'(Store_Err), 32'd1);
      check("mis sw noreq", 32'(Mem_Req), 32'd0);
      tick();
      issue(3'b001, 32'h101, 32'h0000_BEEF);
      check("mis sh err", 32'(Store_Err), 32'd1);
      check("mis sh noreq", 32'(Mem_Req), 32'd0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
